// File: rtl/line_refill_engine.sv
// Line refill engine: fetches one cache line beat-by-beat from backing memory,
// assembles it and queues {index, tag, line} in a small fill FIFO for the cache.
module line_refill_engine #(
  parameter int unsigned LINE_WIDTH     = 512,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned INDEX_WIDTH    = 8,
  parameter int unsigned TAG_WIDTH      = 18,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PTR_WIDTH      = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [INDEX_WIDTH+TAG_WIDTH-1:0] req_line_addr,
  output logic                             mem_rd_valid,
  input  logic                             mem_rd_ready,
  output logic [31:0]                      mem_rd_addr,
  input  logic                             mem_resp_valid,
  input  logic [WORD_WIDTH-1:0]            mem_resp_data,
  input  logic                             fill_pop,
  output logic                             fill_empty,
  output logic                             fill_full,
  output logic [PTR_WIDTH:0]               fill_count,
  output logic [INDEX_WIDTH-1:0]           fill_index,
  output logic [TAG_WIDTH-1:0]             fill_tag,
  output logic [LINE_WIDTH-1:0]            fill_data,
  output logic                             busy
);

  localparam int unsigned LA_W   = INDEX_WIDTH + TAG_WIDTH;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFS_W  = ADDR_W - LA_W;
  localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_W  = PTR_WIDTH + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_PUSH} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    logic [LINE_WIDTH-1:0]  line;
  } fill_entry_t;

  state_t                                   state_q, state_d;
  logic [BEAT_W-1:0]                        beat_q, beat_d;
  logic [LA_W-1:0]                          line_addr_q, line_addr_d;
  logic                                     req_ready_d, mem_rd_valid_d, busy_d;
  logic [ADDR_W-1:0]                        mem_rd_addr_d;
  logic                                     push_en, pop_en;
  logic [CNT_W-1:0]                         count_d;
  logic [PTR_WIDTH-1:0]                     wr_ptr_q, rd_ptr_q;
  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_buf;
  fill_entry_t                              fifo_mem [FIFO_DEPTH];

  // Next-state, FIFO handshake and next values of the registered outputs
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    line_addr_d    = line_addr_q;
    push_en        = 1'b0;
    pop_en         = 1'b0;
    count_d        = fill_count;
    req_ready_d    = 1'b0;
    mem_rd_valid_d = 1'b0;
    busy_d         = 1'b0;
    mem_rd_addr_d  = mem_rd_addr;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          line_addr_d = req_line_addr;
          beat_d      = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_rd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_PUSH;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_PUSH: begin
        // A pop in the same cycle frees the slot even when the FIFO is full
        if ((fill_count != FULL_CNT) || fill_pop) begin
          push_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pop_en         = fill_pop && (fill_count != '0);
    count_d        = fill_count + CNT_W'(push_en) - CNT_W'(pop_en);
    req_ready_d    = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    mem_rd_valid_d = (state_d == ST_ISSUE);
    if (mem_rd_valid_d) begin
      mem_rd_addr_d = {line_addr_d, OFS_W'(0)} + ADDR_W'({beat_d, 2'b00});
    end
  end

  // FSM state, beat counter, latched request and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      line_addr_q  <= '0;
      req_ready    <= 1'b1;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_addr_q  <= line_addr_d;
      req_ready    <= req_ready_d;
      mem_rd_valid <= mem_rd_valid_d;
      mem_rd_addr  <= mem_rd_addr_d;
      busy         <= busy_d;
    end
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_count <= '0;
      fill_empty <= 1'b1;
      fill_full  <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      fill_count <= count_d;
      fill_empty <= (count_d == '0);
      fill_full  <= (count_d == FULL_CNT);
    end
  end

  // Line assembly buffer; contents are don't-care until a full line has landed
  always_ff @(posedge clk) begin
    if ((state_q == ST_WAIT) && mem_resp_valid) line_buf[beat_q] <= mem_resp_data;
  end

  // FIFO storage; no reset needed since the flags gate validity
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_mem[wr_ptr_q] <= {line_addr_q[INDEX_WIDTH-1:0], line_addr_q[LA_W-1:INDEX_WIDTH],
                             LINE_WIDTH'(line_buf)};
    end
  end

  assign fill_index = fifo_mem[rd_ptr_q].index;
  assign fill_tag   = fifo_mem[rd_ptr_q].tag;
  assign fill_data  = fifo_mem[rd_ptr_q].line;

endmodule
